// File: rtl/gainv_ramp_ctrl_if.sv
// Control-side bundle of the GAINV gain ramp controller: ramp request and
// parameters in, handshake/status and path drive signals out.
interface gainv_ramp_ctrl_if #(
    parameter int WIDTH = 12,
    parameter int DIV_W = 8
);
    logic             Req;
    logic [WIDTH-1:0] Target;
    logic [WIDTH-1:0] Step;
    logic [DIV_W-1:0] Interval;
    logic             Abort;
    logic             Ack;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] GainD;
    logic             GainEN;
    logic [WIDTH-1:0] Current;

    modport master (
        output Req, Target, Step, Interval, Abort,
        input  Ack, Busy, Done, GainD, GainEN, Current
    );

    modport slave (
        input  Req, Target, Step, Interval, Abort,
        output Ack, Busy, Done, GainD, GainEN, Current
    );
endinterface

// File: rtl/gainv_ramp_ctrl.sv
// Ramps the GAINV voltage-path gain code toward a requested target in bounded
// steps, pulsing the path load enable once each code has crossed PIPE_LAT stages.
module gainv_ramp_ctrl #(
    parameter int WIDTH    = 12,
    parameter int PIPE_LAT = 2,
    parameter int DIV_W    = 8
) (
    input  logic               Clock,
    input  logic               nReset,
    gainv_ramp_ctrl_if.slave   bus
);

    localparam int PL_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int CNT_W = (DIV_W > PL_W) ? DIV_W : PL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] step_q;
    logic [DIV_W-1:0] interval_q;

    logic             ack;
    logic             done;
    logic             gain_en;
    logic [WIDTH-1:0] gain_d;
    logic [WIDTH-1:0] current;

    // One bounded step from cur toward tgt, computed one bit wider so that
    // neither the sum nor the difference can wrap; the result never passes tgt.
    function automatic logic [WIDTH-1:0] sat_step(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tgt,
        input logic [WIDTH-1:0] stp
    );
        logic [WIDTH:0] wide;
        if (tgt > cur) begin
            wide = {1'b0, cur} + {1'b0, stp};
            sat_step = (wide >= {1'b0, tgt}) ? tgt : wide[WIDTH-1:0];
        end else begin
            wide = {1'b0, cur} - {1'b0, stp};
            sat_step = (wide[WIDTH] || (wide <= {1'b0, tgt})) ? tgt : wide[WIDTH-1:0];
        end
    endfunction

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            target_q   <= '0;
            step_q     <= '0;
            interval_q <= '0;
            ack        <= 1'b0;
            done       <= 1'b0;
            gain_en    <= 1'b0;
            gain_d     <= '0;
            current    <= '0;
        end else begin
            ack     <= 1'b0;
            done    <= 1'b0;
            gain_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Req) begin
                        ack        <= 1'b1;
                        target_q   <= bus.Target;
                        step_q     <= (bus.Step == '0) ? WIDTH'(1) : bus.Step;
                        interval_q <= bus.Interval;
                        state      <= (bus.Target == current) ? S_DONE : S_STEP;
                    end
                end
                S_STEP: begin
                    if (bus.Abort) begin
                        state <= S_IDLE;
                    end else begin
                        gain_d <= sat_step(current, target_q, step_q);
                        cnt    <= CNT_W'(PIPE_LAT - 1);
                        state  <= S_SETTLE;
                    end
                end
                // GainD is frozen here so it reaches the load register before EN.
                S_SETTLE: begin
                    if (bus.Abort) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        gain_en <= 1'b1;
                        current <= gain_d;
                        state   <= S_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                // The commit already happened on entry, so an abort here keeps it.
                S_LOAD: begin
                    if (bus.Abort) begin
                        state <= S_IDLE;
                    end else if (current == target_q) begin
                        state <= S_DONE;
                    end else if (interval_q == '0) begin
                        state <= S_STEP;
                    end else begin
                        cnt   <= CNT_W'(interval_q) - CNT_W'(1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.Abort) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state <= S_STEP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Ack     = ack;
    assign bus.Busy    = (state != S_IDLE);
    assign bus.Done    = done;
    assign bus.GainD   = gain_d;
    assign bus.GainEN  = gain_en;
    assign bus.Current = current;

endmodule
